// File: rtl/dmem_bytelane.sv
// Byte-lane data memory with RISC-V load/store sizing, alignment faults and
// a fixed, parameterised response latency.
module dmem_bytelane #(
    parameter int DEPTH = 128,
    parameter int WAIT  = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [3:0] CNT_LOAD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    logic [1:0]    state;
    logic [3:0]    cnt;
    logic [31:0]   mem [DEPTH];
    logic [31:0]   rdata_q;
    logic          fault_q;

    logic          accept;
    logic          oob;
    logic          misalign;
    logic          bad_op;
    logic          fault;
    logic [AW-1:0] widx;
    logic [3:0]    be;
    logic [31:0]   wword;
    logic [31:0]   rword;
    logic [7:0]    lbyte;
    logic [15:0]   lhalf;
    logic [31:0]   ext;

    assign req_ready = (state == ST_IDLE) && !reset;
    assign accept    = req_valid && req_ready;
    assign widx      = req_addr[AW+1:2];
    assign rword     = mem[widx];

    // Request decode: any of out-of-range, misaligned or illegal funct3 rejects it.
    always_comb begin
        oob      = (req_addr >> (AW + 2)) != 32'd0;
        misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        bad_op   = req_we ? (req_funct3[2] || (req_funct3[1:0] == 2'b11))
                          : ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11));
        fault    = oob || misalign || bad_op;
    end

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        be    = 4'b1111;
        wword = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                be    = 4'b0001 << req_addr[1:0];
                wword = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                be    = req_addr[1] ? 4'b1100 : 4'b0011;
                wword = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        lbyte = rword[{req_addr[1:0], 3'b000} +: 8];
        lhalf = req_addr[1] ? rword[31:16] : rword[15:0];
        case (req_funct3)
            3'b000:  ext = {{24{lbyte[7]}}, lbyte};
            3'b100:  ext = {24'd0, lbyte};
            3'b001:  ext = {{16{lhalf[15]}}, lhalf};
            3'b101:  ext = {16'd0, lhalf};
            default: ext = rword;
        endcase
    end

    // NOTE: the storage array has no reset; contents must survive a reset and a resettable RAM cannot map to block memory.
    always_ff @(posedge clk) begin
        if (accept && req_we && !fault) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[widx][8*i +: 8] <= wword[8*i +: 8];
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= 4'd0;
            rdata_q <= 32'd0;
            fault_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state   <= (WAIT > 0) ? ST_WAIT : ST_RESP;
                        cnt     <= CNT_LOAD;
                        rdata_q <= (req_we || fault) ? 32'd0 : ext;
                        fault_q <= fault;
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd0) state <= ST_RESP;
                    else             cnt   <= cnt - 4'd1;
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign rsp_valid = (state == ST_RESP);
    assign rsp_rdata = rsp_valid ? rdata_q : 32'd0;
    assign rsp_fault = rsp_valid && fault_q;

endmodule

// File: tb/tb_dmem_bytelane.sv
// Scoreboard bench: a WAIT=0 instance for data/fault behaviour and a WAIT=3
// instance for handshake timing and mid-flight reset.
module tb_dmem_bytelane;

    localparam int DEPTH = 128;
    localparam int NBYTE = DEPTH * 4;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;

    logic        v0, we0, rdy0, rv0, flt0;
    logic [2:0]  f30;
    logic [31:0] a0, wd0, rd0;
    logic        v3, we3, rdy3, rv3, flt3;
    logic [2:0]  f33;
    logic [31:0] a3, wd3, rd3;

    exp_t        q0[$];
    exp_t        q3[$];
    logic [7:0]  mb [NBYTE];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_bytelane #(.DEPTH(DEPTH), .WAIT(0)) dut0 (
        .clk(clk), .reset(reset), .req_valid(v0), .req_ready(rdy0), .req_we(we0),
        .req_funct3(f30), .req_addr(a0), .req_wdata(wd0),
        .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_fault(flt0)
    );

    dmem_bytelane #(.DEPTH(DEPTH), .WAIT(3)) dut3 (
        .clk(clk), .reset(reset), .req_valid(v3), .req_ready(rdy3), .req_we(we3),
        .req_funct3(f33), .req_addr(a3), .req_wdata(wd3),
        .rsp_valid(rv3), .rsp_rdata(rd3), .rsp_fault(flt3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: flat byte array, little-endian assembly.
    function automatic logic m_fault(input logic we, input logic [2:0] f3, input logic [31:0] a);
        if (a >= 32'(NBYTE)) return 1'b1;
        if (we) begin
            if (!(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b1;
        end else if (f3 inside {3'd3, 3'd6, 3'd7}) begin
            return 1'b1;
        end
        if ((f3 == 3'd1 || f3 == 3'd5) && a[0]) return 1'b1;
        if (f3 == 3'd2 && a[1:0] != 2'b00) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a);
        int i;
        logic [15:0] h;
        if (m_fault(1'b0, f3, a)) return 32'd0;
        i = int'(a);
        h = {mb[i+1], mb[i]};
        case (f3)
            3'd0:    return {{24{mb[i][7]}}, mb[i]};
            3'd4:    return {24'd0, mb[i]};
            3'd1:    return {{16{h[15]}}, h};
            3'd5:    return {16'd0, h};
            default: return {mb[i+3], mb[i+2], mb[i+1], mb[i]};
        endcase
    endfunction

    task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        int i;
        i = int'(a);
        mb[i] = wd[7:0];
        if (f3 != 3'd0) mb[i+1] = wd[15:8];
        if (f3 == 3'd2) begin
            mb[i+2] = wd[23:16];
            mb[i+3] = wd[31:24];
        end
    endtask

    task automatic drive(input bit sel, input logic v, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        if (sel) begin
            v3 = v; we3 = we; f33 = f3; a3 = a; wd3 = wd;
        end else begin
            v0 = v; we0 = we; f30 = f3; a0 = a; wd0 = wd;
        end
    endtask

    task automatic scramble(input bit sel);
        drive(sel, 1'b0, 1'($urandom), 3'($urandom), $urandom, $urandom);
    endtask

    function automatic logic ready(input bit sel);
        return sel ? rdy3 : rdy0;
    endfunction

    task automatic issue(input bit sel, input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] er, input logic ef);
        int   waited;
        exp_t e;
        waited = 0;
        @(negedge clk);
        drive(sel, 1'b1, we, f3, a, wd);
        while (!ready(sel) && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (!ready(sel)) begin
            check(sel ? "d3_accept_timeout" : "d0_accept_timeout", 32'(ready(sel)), 32'd1);
        end else begin
            e.rdata = er;
            e.fault = ef;
            e.acc   = cyc;
            if (sel) q3.push_back(e);
            else     q0.push_back(e);
            if (!sel && we && !ef) model_store(f3, a, wd);
        end
        @(posedge clk);
        #1;
        scramble(sel);
    endtask

    task automatic mreq(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        issue(1'b0, we, f3, a, wd, we ? 32'd0 : m_load(f3, a), m_fault(we, f3, a));
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (rv0) begin
                if (q0.size() == 0) begin
                    check("d0_unexpected_rsp", 32'(rv0), 32'd0);
                end else begin
                    e = q0.pop_front();
                    check("d0_rdata", rd0, e.rdata);
                    check("d0_fault", 32'(flt0), 32'(e.fault));
                    check("d0_latency", 32'(cyc - e.acc), 32'd1);
                end
            end else begin
                check("d0_idle_rdata", rd0, 32'd0);
                check("d0_idle_fault", 32'(flt0), 32'd0);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (rv3) begin
                if (q3.size() == 0) begin
                    check("d3_unexpected_rsp", 32'(rv3), 32'd0);
                end else begin
                    e = q3.pop_front();
                    check("d3_rdata", rd3, e.rdata);
                    check("d3_fault", 32'(flt3), 32'(e.fault));
                    check("d3_latency", 32'(cyc - e.acc), 32'd4);
                end
            end else begin
                check("d3_idle_rdata", rd3, 32'd0);
                check("d3_idle_fault", 32'(flt3), 32'd0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int first;
        int n;
        int waited;
        logic [31:0] ra;
        scramble(1'b0);
        scramble(1'b1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_ready0", 32'(rdy0), 32'd0);
        check("rst_valid0", 32'(rv0), 32'd0);
        check("rst_rdata0", rd0, 32'd0);
        check("rst_fault0", 32'(flt0), 32'd0);
        check("rst_ready3", 32'(rdy3), 32'd0);
        check("rst_valid3", 32'(rv3), 32'd0);
        reset = 1'b0;
        #1;
        check("post_rst_ready0", 32'(rdy0), 32'd1);
        check("post_rst_ready3", 32'(rdy3), 32'd1);
        mon_en = 1'b1;

        for (int i = 0; i < 8; i++) mreq(1'b1, 3'd2, 32'(4 * i), 32'hC0DE_0000 + 32'(i));
        mreq(1'b1, 3'd2, 32'h1FC, 32'h0BAD_F00D);

        // Byte-lane merge
        issue(0, 1, 3'd2, 32'h8, 32'h1122_3344, 32'h0, 0);
        issue(0, 1, 3'd0, 32'h9, 32'h0000_00AB, 32'h0, 0);
        issue(0, 0, 3'd2, 32'h8, 32'h0, 32'h1122_AB44, 0);
        issue(0, 1, 3'd1, 32'h6, 32'hFFFF_BEEF, 32'h0, 0);
        issue(0, 0, 3'd2, 32'h4, 32'h0, 32'hBEEF_0001, 0);

        // Sign / zero extension
        issue(0, 1, 3'd2, 32'h8, 32'h80FF_7F01, 32'h0, 0);
        issue(0, 0, 3'd0, 32'hA, 32'h0, 32'hFFFF_FFFF, 0);
        issue(0, 0, 3'd4, 32'hA, 32'h0, 32'h0000_00FF, 0);
        issue(0, 0, 3'd1, 32'hA, 32'h0, 32'hFFFF_80FF, 0);
        issue(0, 0, 3'd5, 32'hA, 32'h0, 32'h0000_80FF, 0);
        issue(0, 0, 3'd0, 32'h9, 32'h0, 32'h0000_007F, 0);
        issue(0, 0, 3'd1, 32'h8, 32'h0, 32'h0000_7F01, 0);
        issue(0, 0, 3'd0, 32'hB, 32'h0, 32'hFFFF_FF80, 0);

        // Faults
        issue(0, 0, 3'd2, 32'h6, 32'h0, 32'h0, 1);
        issue(0, 1, 3'd1, 32'h3, 32'h0000_FFFF, 32'h0, 1);
        issue(0, 0, 3'd2, 32'h0, 32'h0, 32'hC0DE_0000, 0);
        issue(0, 0, 3'd2, 32'h200, 32'h0, 32'h0, 1);
        issue(0, 0, 3'd3, 32'h0, 32'h0, 32'h0, 1);
        issue(0, 0, 3'd6, 32'h0, 32'h0, 32'h0, 1);
        issue(0, 1, 3'd4, 32'h0, 32'hFFFF_FFFF, 32'h0, 1);
        issue(0, 1, 3'd2, 32'h202, 32'hFFFF_FFFF, 32'h0, 1);
        issue(0, 0, 3'd2, 32'h0, 32'h0, 32'hC0DE_0000, 0);

        // Last word, no aliasing onto word 0
        issue(0, 1, 3'd2, 32'h1FC, 32'hDEAD_BEEF, 32'h0, 0);
        issue(0, 0, 3'd2, 32'h1FC, 32'h0, 32'hDEAD_BEEF, 0);
        issue(0, 0, 3'd2, 32'h0, 32'h0, 32'hC0DE_0000, 0);
        issue(0, 1, 3'd0, 32'h1FF, 32'h0000_005A, 32'h0, 0);
        issue(0, 0, 3'd2, 32'h1FC, 32'h0, 32'h5AAD_BEEF, 0);

        // Model-driven mixed traffic
        for (int k = 0; k < 40; k++) begin
            n = int'($urandom_range(0, 7));
            if (n < 6)       ra = $urandom_range(0, 31);
            else if (n == 6) ra = $urandom_range(508, 511);
            else             ra = $urandom_range(512, 600);
            mreq(1'($urandom), 3'($urandom), ra, $urandom);
        end

        // Continuous req_valid on the WAIT=3 instance
        issue(1, 1, 3'd2, 32'h10, 32'h1234_5678, 32'h0, 0);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 3'd2, 32'h10, 32'h0);
        first = -1;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) @(negedge clk);
            if (first >= 0) check("d3_hs_ready", 32'(rdy3), 32'(((cyc - first) % 5) == 0));
            if (rdy3) begin
                if (first < 0) first = cyc;
                q3.push_back('{rdata: 32'h1234_5678, fault: 1'b0, acc: cyc});
            end
        end
        @(posedge clk);
        #1;
        scramble(1'b1);

        // Reset while a load is in flight
        issue(1, 1, 3'd2, 32'h14, 32'hCAFE_F00D, 32'h0, 0);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 3'd2, 32'h14, 32'h0);
        waited = 0;
        while (!rdy3 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check("d3_rst_accept", 32'(rdy3), 32'd1);
        n = cyc;
        @(posedge clk);
        #1;
        scramble(1'b1);
        while (cyc < n + 2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("d3_ready_in_reset", 32'(rdy3), 32'd0);
        check("d0_ready_in_reset", 32'(rdy0), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("d3_ready_after_reset", 32'(rdy3), 32'd1);
        repeat (8) @(negedge clk);
        issue(1, 0, 3'd2, 32'h14, 32'h0, 32'hCAFE_F00D, 0);
        issue(1, 0, 3'd2, 32'h10, 32'h0, 32'h1234_5678, 0);
        mreq(1'b0, 3'd2, 32'h1FC, 32'h0);
        mreq(1'b0, 3'd2, 32'h8, 32'h0);

        repeat (10) @(negedge clk);
        check("d0_queue_drained", 32'(q0.size()), 32'd0);
        check("d3_queue_drained", 32'(q3.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
